// File: rtl/internal_paths_pkg.sv
// Shared types and defaults for the internal_paths capture stage.
package internal_paths_pkg;

  // Capture FSM states: wait for enable, look for a start bit, shift data bits.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    SHIFT = 2'd2
  } cap_state_e;

  // Line level that marks the start of a frame.
  localparam logic START_LVL = 1'b1;

  // Default frame width and activity counter width.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/internal_paths_retime.sv
// Two-flop retimer for the serial input; a separate module so timing reports
// name this path on its own.
module internal_paths_retime (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic r1_q;
  logic r2_q;

  // Retime the input through two rising-edge flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r1_q <= 1'b0;
      r2_q <= 1'b0;
    end else begin
      r1_q <= d_i;
      r2_q <= r1_q;
    end
  end

  assign q_o = r2_q;

endmodule

// File: rtl/internal_paths_capture.sv
// Capture stage: retimes a framed serial stream (start bit + WIDTH data bits,
// LSB first), deserialises it and presents words on a valid/ready port.
// Also keeps a saturating count of transitions on the retimed input.
module internal_paths_capture
  import internal_paths_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             en,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  output logic             overflow,
  input  logic             clr_overflow,
  output logic [CNT_W-1:0] toggle_count,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic             r2_s;
  logic             r3_q;
  cap_state_e       state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  // Only WIDTH-1 bits are stored; the last bit is taken straight from the line.
  logic [WIDTH-2:0] sh_q, sh_d;
  logic [WIDTH-1:0] word_s;
  logic             done_s;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;

  internal_paths_retime u_retime (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (in),
    .q_o    (r2_s)
  );

  assign word_s = {r2_s, sh_q};

  // Next-state logic: start-bit hunt, bit shifting and frame completion.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    done_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = HUNT;
        else    state_d = IDLE;
      end
      HUNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (r2_s == START_LVL) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end else begin
          state_d = HUNT;
        end
      end
      SHIFT: begin
        if (!en) begin
          // Partial word is simply abandoned.
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          sh_d = word_s[WIDTH-1:1];
          if (bit_cnt_q == LAST_BIT) begin
            done_s    = 1'b1;
            state_d   = HUNT;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Output word register and sticky overflow; setting overflow beats clearing it.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr_overflow) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
    if (done_s) begin
      if (!valid_q || word_ready) begin
        data_d  = word_s;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Saturating transition counter on the retimed input.
  always_comb begin
    if ((r2_s != r3_q) && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    else                                             cnt_d = cnt_q;
  end

  // FSM state, bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
    end
  end

  // Output word, valid and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Previous retimed bit, activity counter and registered busy decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_q   <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      r3_q   <= r2_s;
      cnt_q  <= cnt_d;
      busy_q <= (state_d == SHIFT);
    end
  end

  assign word_data    = data_q;
  assign word_valid   = valid_q;
  assign overflow     = ovf_q;
  assign toggle_count = cnt_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_internal_paths_capture.sv
// Directed bench for internal_paths_capture with a frame-level reference model.
module tb_internal_paths_capture;

  localparam int W     = 8;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, in_s, en_s, ready_s, clr_s;
  logic [W-1:0]  word_data;
  logic          word_valid, overflow, busy;
  logic [CW-1:0] toggle_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // accepted-word log (data, cycle index)
  int acc_d[$];
  int acc_t[$];

  // reference model state
  bit     m_line[$];      // bits in flight between `in` and the frame parser
  bit     m_prev;
  int     m_cnt;
  int     m_mode;         // 0 disabled, 1 waiting for start, 2 collecting bits
  int     m_pos;
  int     m_acc;
  int     m_data;
  bit     m_valid, m_ovf, m_busy;

  internal_paths_capture #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in           (in_s),
    .en           (en_s),
    .word_ready   (ready_s),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .overflow     (overflow),
    .clr_overflow (clr_s),
    .toggle_count (toggle_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Reference model: the parser sees `in` two edges late.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_line = '{1'b0, 1'b0};
      m_prev = 1'b0; m_cnt = 0; m_mode = 0; m_pos = 0; m_acc = 0;
      m_data = 0; m_valid = 1'b0; m_ovf = 1'b0; m_busy = 1'b0;
    end else begin
      bit s;
      bit done;
      bit drop;
      s    = m_line[0];
      done = 1'b0;
      drop = 1'b0;
      if (!en_s) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (s) begin m_mode = 2; m_pos = 0; m_acc = 0; end
      end else begin
        m_acc = m_acc + (int'(s) << m_pos);
        m_pos = m_pos + 1;
        if (m_pos == W) begin done = 1'b1; m_mode = 1; end
      end
      if (done) begin
        if (!m_valid || ready_s) begin m_data = m_acc; m_valid = 1'b1; end
        else drop = 1'b1;
      end else if (m_valid && ready_s) begin
        m_valid = 1'b0;
      end
      if (drop) m_ovf = 1'b1;
      else if (clr_s) m_ovf = 1'b0;
      if (s != m_prev && m_cnt < CMAX) m_cnt = m_cnt + 1;
      m_prev = s;
      m_busy = (m_mode == 2);
      void'(m_line.pop_front());
      m_line.push_back(in_s);
    end
  end

  // Compare DUT against the model every cycle, and log accepted words.
  always @(posedge clk) begin
    #1;
    cyc_n++;
    chk("word_valid", 32'(word_valid), 32'(m_valid));
    chk("word_data", 32'(word_data), 32'(m_data));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("toggle_count", 32'(toggle_count), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(m_busy));
    if (word_valid && ready_s) begin
      acc_d.push_back(int'(word_data));
      acc_t.push_back(cyc_n);
    end
  end

  task automatic cyc(input logic b);
    in_s = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic send_frame(input logic [W-1:0] w);
    cyc(1'b1);
    for (int i = 0; i < W; i++) cyc(w[i]);
  endtask

  initial begin
    rst_n = 1'b0; in_s = 1'b0; en_s = 1'b0; ready_s = 1'b0; clr_s = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: reset in the middle of a frame
    en_s = 1'b1;
    idle(3);
    for (int i = 0; i < 5; i++) cyc(1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_data", 32'(word_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_toggle", 32'(toggle_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    in_s = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(15);
    chk("rst_no_word", 32'(word_valid), 32'd0);

    // 2: single frame, valid two edges after the last bit
    ready_s = 1'b1;
    send_frame(8'hA5);
    idle(1);
    chk("basic_early", 32'(word_valid), 32'd0);
    idle(1);
    chk("basic_valid", 32'(word_valid), 32'd1);
    chk("basic_data", 32'(word_data), 32'hA5);
    chk("basic_ovf", 32'(overflow), 32'd0);
    idle(1);
    chk("basic_one_cycle", 32'(word_valid), 32'd0);

    // 3: back-to-back frames
    acc_d.delete(); acc_t.delete();
    send_frame(8'h3C);
    send_frame(8'hC3);
    idle(4);
    chk("b2b_count", 32'(acc_d.size()), 32'd2);
    if (acc_d.size() == 2) begin
      chk("b2b_first", 32'(acc_d[0]), 32'h3C);
      chk("b2b_second", 32'(acc_d[1]), 32'hC3);
      chk("b2b_spacing", 32'(acc_t[1] - acc_t[0]), 32'd9);
    end

    // 4: backpressure and overflow
    ready_s = 1'b0;
    idle(2);
    send_frame(8'h11);
    send_frame(8'h22);
    idle(3);
    chk("bp_data", 32'(word_data), 32'h11);
    chk("bp_valid", 32'(word_valid), 32'd1);
    chk("bp_ovf", 32'(overflow), 32'd1);
    ready_s = 1'b1;
    idle(1);
    chk("bp_accept", 32'(word_valid), 32'd0);
    chk("bp_hold", 32'(word_data), 32'h11);
    clr_s = 1'b1;
    idle(1);
    clr_s = 1'b0;
    chk("bp_clear", 32'(overflow), 32'd0);

    // 5: abort mid-frame, then recover
    idle(2);
    for (int i = 0; i < 5; i++) cyc(1'b1);
    en_s = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1'b1);
    idle(4);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(word_valid), 32'd0);
    en_s = 1'b1;
    idle(2);
    send_frame(8'h5A);
    idle(2);
    chk("abort_recover_valid", 32'(word_valid), 32'd1);
    chk("abort_recover_data", 32'(word_data), 32'h5A);

    // 6: counter saturation
    @(negedge clk);
    rst_n = 1'b0; en_s = 1'b0; in_s = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cyc((i % 2) == 0);
    idle(2);
    chk("cnt_sat", 32'(toggle_count), 32'd15);
    for (int i = 0; i < 6; i++) cyc((i % 2) == 0);
    idle(2);
    chk("cnt_hold", 32'(toggle_count), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
